// File: rtl/micro_sequencer.sv
// Microstate controller for the multicycle CPU: sequences the 4-bit ROM address,
// dispatches on the opcode, halts on illegal opcodes/states and counts retired instructions.
module micro_sequencer #(
  parameter int OPW  = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            mem_ready,
  input  logic [OPW-1:0]  opcode,
  output logic [3:0]      state,
  output logic            instr_done,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_LWWB     = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RWB      = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            retire;

  // An instruction retires in its last state; MEMWRITE only once memory accepts the store.
  assign retire = enable &&
                  ((state_q == S_LWWB) || (state_q == S_RWB) || (state_q == S_BEQ) ||
                   (state_q == S_JUMP) || (state_q == S_ADDIWB) ||
                   ((state_q == S_MEMWRITE) && mem_ready));

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (enable) begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADDR;
          else if (opcode == OP_R)                    state_d = S_REXEC;
          else if (opcode == OP_BEQ)                  state_d = S_BEQ;
          else if (opcode == OP_J)                    state_d = S_JUMP;
          else if (opcode == OP_ADDI)                 state_d = S_ADDIEXEC;
          else begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        end
        S_MEMADDR: begin
          if (opcode == OP_LW)      state_d = S_MEMREAD;
          else if (opcode == OP_SW) state_d = S_MEMWRITE;
          else begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        end
        S_MEMREAD:  if (mem_ready) state_d = S_LWWB;
        S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
        S_REXEC:    state_d = S_RWB;
        S_ADDIEXEC: state_d = S_ADDIWB;
        S_LWWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: state_d = S_FETCH;
        S_HALT:     state_d = S_HALT;
        // Unused encodings 12-14 are treated as corruption and trapped.
        default: begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      endcase
      if (retire) count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_done  = retire;
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: vector table, hand sequences for halt/wrap/abort,
// and a randomized run against a per-opcode microstate-path model.
module tb_micro_sequencer;

  localparam int CNTW = 8;
  localparam int CMOD = 1 << CNTW;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic            clk = 1'b0;
  logic            reset, enable, mem_ready;
  logic [5:0]      opcode;
  logic [3:0]      state;
  logic            instr_done, halted, illegal;
  logic [CNTW-1:0] instr_count;

  int compared   = 0;
  int mismatched = 0;
  int expCount   = 0;
  int pulses     = 0;
  int path[$];

  micro_sequencer #(.OPW(6), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_ready(mem_ready), .opcode(opcode),
    .state(state), .instr_done(instr_done), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mr;
    logic [5:0] op;
    int         st;
    logic       done;
    logic       halt;
    logic       ill;
    int         cnt;
  } vec_t;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic mr, input logic [5:0] op);
    reset     = rst;
    enable    = en;
    mem_ready = mr;
    opcode    = op;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int st, input logic done,
                             input logic halt, input logic ill, input int cnt);
    checkVal({tag, ".state"}, {28'b0, state}, st);
    checkVal({tag, ".instr_done"}, {31'b0, instr_done}, {31'b0, done});
    checkVal({tag, ".halted"}, {31'b0, halted}, {31'b0, halt});
    checkVal({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
    checkVal({tag, ".instr_count"}, {{(32-CNTW){1'b0}}, instr_count}, cnt % CMOD);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Microstate path an instruction walks through from FETCH, derived from the opcode.
  task automatic buildPath(input logic [5:0] op);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      OP_LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
      OP_SW:   begin path.push_back(2); path.push_back(5); end
      OP_R:    begin path.push_back(6); path.push_back(7); end
      OP_BEQ:  path.push_back(8);
      OP_J:    path.push_back(9);
      default: begin path.push_back(10); path.push_back(11); end
    endcase
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, OP_R);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, OP_R);
    expCount = 0;
    checkOutput("reset", 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // One full instruction with memory always ready; tallies instr_done pulses.
  task automatic runInstr(input logic [5:0] op, input string tag);
    buildPath(op);
    for (int i = 0; i < path.size(); i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, op);
      checkOutput(tag, path[i], (i == path.size() - 1), 1'b0, 1'b0, expCount);
      if (instr_done) pulses++;
      tick();
    end
    expCount = (expCount + 1) % CMOD;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [5:0] legalOps[6];
    logic [5:0] curOp;
    int         idx;
    logic       adv, waitSt, expDone;

    legalOps = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // R-type, LW with two memory stalls, enable freeze in REXEC, illegal opcode.
    vecs.push_back('{1'b1, 1'b1, OP_R,   0,  1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, OP_R,   1,  1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, OP_R,   6,  1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, OP_R,   7,  1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, OP_LW,  0,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, OP_LW,  0,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, OP_LW,  1,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, OP_LW,  2,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, OP_LW,  3,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b0, OP_LW,  3,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, OP_LW,  3,  1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, OP_LW,  4,  1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 1'b1, OP_R,   0,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 1'b1, OP_R,   1,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, OP_R,   6,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, OP_R,   6,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, OP_R,   6,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 1'b1, OP_R,   6,  1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 1'b1, OP_R,   7,  1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, OP_BAD, 0,  1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b1, 1'b1, OP_BAD, 0,  1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b1, 1'b1, OP_BAD, 1,  1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b1, 1'b1, OP_BAD, 15, 1'b0, 1'b1, 1'b1, 3});

    $display("[TB] start");
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].en, vecs[i].mr, vecs[i].op);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].halt,
                  vecs[i].ill, vecs[i].cnt);
      tick();
    end

    // HALT must hold with counter frozen regardless of mem_ready/opcode.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom));
      checkOutput("haltHold", 15, 1'b0, 1'b1, 1'b1, 3);
      tick();
    end
    doReset();

    // Back-to-back SW, BEQ, J, ADDI.
    pulses = 0;
    runInstr(OP_SW, "sw");
    runInstr(OP_BEQ, "beq");
    runInstr(OP_J, "j");
    runInstr(OP_ADDI, "addi");
    applyStimulus(1'b0, 1'b1, 1'b0, OP_R);
    checkVal("b2b.pulses", pulses, 4);
    checkOutput("b2b.end", 0, 1'b0, 1'b0, 1'b0, 4);

    // Opcode no longer a memory op by MEMADDR traps to HALT.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, OP_LW);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, OP_R);
    checkOutput("memaddrBad.pre", 2, 1'b0, 1'b0, 1'b0, 0);
    tick();
    checkOutput("memaddrBad.post", 15, 1'b0, 1'b1, 1'b1, 0);

    // Counter wrap over CMOD jump instructions, then one more.
    doReset();
    for (int i = 0; i < CMOD; i++) runInstr(OP_J, "wrapJ");
    applyStimulus(1'b0, 1'b1, 1'b0, OP_J);
    checkOutput("wrap.zero", 0, 1'b0, 1'b0, 1'b0, 0);
    runInstr(OP_J, "postWrapJ");
    applyStimulus(1'b0, 1'b1, 1'b1, OP_ADDI);
    checkOutput("abort.fetch", 0, 1'b0, 1'b0, 1'b0, 1);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, OP_ADDI);
    checkVal("abort.inAddiExec", {28'b0, state}, 10);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, OP_ADDI);
    checkOutput("abort.after", 0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized legal traffic with stalls and enable gaps vs path model.
    doReset();
    idx = 0;
    curOp = OP_R;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (idx == 0) begin
        curOp = legalOps[$urandom_range(0, 5)];
        buildPath(curOp);
      end
      applyStimulus(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0), curOp);
      waitSt  = (path[idx] == 0) || (path[idx] == 3) || (path[idx] == 5);
      adv     = enable && (!waitSt || mem_ready);
      expDone = adv && (idx == path.size() - 1);
      checkVal("rand.state", {28'b0, state}, path[idx]);
      checkVal("rand.instr_done", {31'b0, instr_done}, {31'b0, expDone});
      checkVal("rand.instr_count", {{(32-CNTW){1'b0}}, instr_count}, expCount);
      tick();
      if (adv) begin
        if (idx == path.size() - 1) begin
          idx = 0;
          expCount = (expCount + 1) % CMOD;
        end else begin
          idx++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-state controller for the multicycle CPU's 16-entry, 17-bit microinstruction ROM. It holds the 4-bit microstate register that addresses the ROM each cycle. The next state comes from dispatch on the decoded instruction opcode and from memory-ready handshakes. It flags illegal opcodes, halts on them, and counts retired instructions.

## Interface
- `OPW`, default 6: opcode width.
- `CNTW`, default 16: retired-instruction counter width.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: when 0, freeze every register.
- `mem_ready`  in  1: memory handshake, sampled only in states 0, 3 and 5.
- `opcode`  in  OPW: instruction-register opcode bits [31:26]. Stable from state 1 until the instruction returns to state 0.
- `state`  out  4: current microstate, driven to the ROM address.
- `instr_done`  out  1: combinational; high in the final cycle of an instruction that will advance at this edge.
- `halted`  out  1: high while in state 15.
- `illegal`  out  1: sticky illegal-opcode / illegal-state flag.
- `instr_count`  out  CNTW: retired instructions, wraps modulo 2^CNTW.

## Operation
- State encoding is fixed and equals the ROM address:
  - 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 LWWB, 5 MEMWRITE
  - 6 REXEC, 7 RWB, 8 BEQ, 9 JUMP, 10 ADDIEXEC, 11 ADDIWB, 15 HALT
  - 12–14 are unused.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- Transitions (apply only when `enable`=1 and `reset`=0):
  - 0 → 1 if `mem_ready`, else stay in 0.
  - 1 → dispatch: LW/SW → 2, R → 6, BEQ → 8, J → 9, ADDI → 10, any other opcode → 15 with `illegal` set.
  - 2 → 3 on LW, → 5 on SW. Any other opcode in state 2 → 15 with `illegal` set.
  - 3 → 4 if `mem_ready`, else stay in 3.
  - 5 → 0 if `mem_ready`, else stay in 5.
  - 4 → 0; 6 → 7; 7 → 0; 8 → 0; 9 → 0; 10 → 11; 11 → 0.
  - 12, 13, 14 → 15 with `illegal` set.
  - 15 → 15; only `reset` leaves HALT.
- `instr_done` = `enable` AND (state ∈ {4, 7, 8, 9, 11}, or state = 5 with `mem_ready`).
- `instr_count` increments at the same edge that `instr_done` marks. It wraps from all-ones to 0.
- `halted` = (state == 15). While halted, `instr_done` = 0 and `instr_count` is frozen.
- `illegal` stays set until `reset`.

## Timing
- Reset is synchronous and has priority over `enable`. At the first edge with `reset`=1: `state`=0, `illegal`=0, `instr_count`=0, `halted`=0, `instr_done`=0.
- Reset asserted mid-instruction aborts it; that instruction is not counted.
- `state` is registered. The ROM output for a state is valid in the same cycle that state is held.
- Latency with `mem_ready` held at 1, from entering state 0 to re-entering state 0:
  - LW 5 cycles; SW 4; R 4; ADDI 4; BEQ 3; J 3.
  - Each cycle `mem_ready` is low in state 0, 3 or 5 adds one cycle.
- `enable`=0 holds `state`, `illegal` and `instr_count`, forces `instr_done`=0, and ignores `mem_ready`.
- `enable` and `mem_ready` high in the same cycle in states 0/3/5: advance.
- `instr_count` wrap and `instr_done` coincide normally: the count goes all-ones → 0 and the pulse is emitted.

## Test plan
- Reset, then an R-type (opcode 000000) with `mem_ready`=1 → states 0,1,6,7,0; `instr_done` high only in state 7; `instr_count`=1.
- LW (100011) with `mem_ready` low for 2 cycles in state 3 → states 0,1,2,3,3,3,4,0; 7 cycles; count +1.
- SW, BEQ, J, ADDI run back to back → states 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11; `instr_count`=4; exactly 4 `instr_done` pulses.
- Opcode 111111 at DECODE → state 15, `halted`=1, `illegal`=1; both hold for 10+ cycles with `instr_count` unchanged; `reset` returns `state` to 0 and `illegal` to 0.
- `enable`=0 for 3 cycles while in state 6 → `state` stays 6, no pulse; after release the sequence resumes 7,0.
- Preload near wrap: run 65536 one-cycle-ready J instructions from reset → `instr_count` returns to 0; `reset` asserted in state 10 → next `state`=0 and the count is unchanged by the aborted ADDI.
